fifo_rr_scheduler: RTL and testbench
====================================

// Module: fifo_rr_scheduler
// PURPOSE
//  Round-robin drain scheduler that shares one output stream between NUM_CH ram_fifo read ports.
//  - Grants one channel at a time and holds the grant for up to BURST_LEN beats.
//  - Muxes the granted channel's data into a single registered output stage, tagged with its channel number.
//  - Sits between the per-channel ram_fifo rd_* ports and the shared downstream consumer (chain egress).
// PARAMETERS
//  NUM_CH      4                     number of requesting channels (>=2)
//  DATA_WIDTH  32                    data width per channel
//  BURST_LEN   16                    maximum beats per grant (>=1)
//  CH_WIDTH    $clog2(NUM_CH)        width of channel index
//  CNT_WIDTH   $clog2(BURST_LEN+1)   width of beat counter
// PORTS
//  clk        in   1                     single clock
//  rstn       in   1                     reset, synchronous, active-low
//  ch_enable  in   NUM_CH                per-channel enable; 0 = channel excluded from arbitration
//  in_valid   in   NUM_CH                per-channel valid (ram_fifo rd_valid)
//  in_data    in   NUM_CH*DATA_WIDTH     per-channel data, ch i at [i*DATA_WIDTH +: DATA_WIDTH]
//  in_ready   out  NUM_CH                per-channel ready (ram_fifo rd_ready)
//  out_valid  out  1                     output beat valid
//  out_data   out  DATA_WIDTH            output beat data
//  out_ch     out  CH_WIDTH              source channel of output beat
//  out_ready  in   1                     downstream ready
//  busy       out  1                     1 while state==GRANT
//  cur_ch     out  CH_WIDTH              currently/last granted channel
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): state=IDLE, out_valid=0, out_data=0, out_ch=0, busy=0, beat_cnt=0,
//    last_grant=NUM_CH-1 (so ch0 wins first), cur_ch=NUM_CH-1. in_ready=0 while in IDLE.
//    Reset mid-burst discards the held output beat; no partial state survives.
//  - cken = !out_valid || out_ready. Transfer on ch i = in_valid[i] && in_ready[i].
//  - in_ready[i] = (state==GRANT) && (grant==i) && ch_enable[i] && cken; combinational, all others 0.
//  - Output stage: when cken, out_valid<=transfer, out_data<=in_data[grant], out_ch<=grant.
//    When !cken all out_* hold (stable while out_valid && !out_ready).
//  - FSM IDLE:
//    - req = in_valid & ch_enable. If req!=0, grant <= first set index scanning last_grant+1, +2, ... mod NUM_CH.
//    - beat_cnt<=0, ->GRANT. No transfer occurs in IDLE.
//  - FSM GRANT (priority order):
//    1. !ch_enable[grant] -> IDLE, in any cycle including stall.
//    2. transfer && beat_cnt==BURST_LEN-1 -> IDLE.
//    3. cken && !in_valid[grant] -> IDLE (source empty; a ram_fifo pipeline bubble also releases).
//    4. Otherwise stay; beat_cnt+1 on each transfer.
//    - On every GRANT->IDLE: last_grant<=grant.
//  - Latency: req in IDLE at cycle t -> in_ready at t+1 -> out_valid at t+2.
//    Each grant change costs exactly one idle cycle (IDLE state).
//  - Fairness: a released channel is not re-granted while any other enabled channel requests.
//  - No data lost or duplicated: each transfer produces exactly one output beat, in source order per channel.
//  - Beat count never exceeds BURST_LEN per grant. BURST_LEN=1 releases after every beat.
// TESTING
//  1. Only ch0 valid with 5 beats, out_ready=1, BURST_LEN=16
//     -> 5 beats out_ch=0 in order, first out_valid 2 cycles after in_valid, then IDLE.
//  2. All 4 ch continuously valid, BURST_LEN=4, out_ready=1
//     -> out_ch 0,0,0,0,1x4,2x4,3x4,0x4...; one bubble between bursts.
//  3. All ch valid, out_ready random 50%
//     -> scoreboard: no drop/dup; out_data/out_ch stable while out_valid&&!out_ready; bursts <=BURST_LEN.
//  4. ch_enable[1]=0, all valid -> ch1 never granted.
//     Drop ch_enable[2] mid-burst -> in_ready[2]=0 same cycle, next grant ch3.
//  5. ch0 drains after 3 beats (valid low) -> release, ch1 granted.
//     ch0 refilled -> not granted until ch1..ch3 served.
//  6. rstn=0 mid-burst with out_valid=1, out_ready=0
//     -> out_valid=0, busy=0 next cycle; first grant after reset is ch0.

Source files
------------

// File: rtl/fifo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// fifo_rr_scheduler
//   Round-robin drain scheduler that shares one output stream between NUM_CH
//   ram_fifo read ports. One channel is granted at a time and keeps the grant
//   for up to BURST_LEN beats. The granted channel's data passes through a
//   single registered output stage and is tagged with its channel number.
//
// Ports
//   clk        single clock
//   rstn       synchronous active-low reset
//   ch_enable  per-channel enable; 0 removes the channel from arbitration
//   in_valid   per-channel valid (ram_fifo rd_valid)
//   in_data    per-channel data, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ready   per-channel ready (ram_fifo rd_ready), combinational
//   out_valid  output beat valid
//   out_data   output beat data
//   out_ch     source channel of the output beat
//   out_ready  downstream ready
//   busy       high while a channel holds the grant
//   cur_ch     currently / most recently granted channel
// -----------------------------------------------------------------------------
module fifo_rr_scheduler #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 32,
   parameter int BURST_LEN  = 16,
   parameter int CH_WIDTH   = $clog2(NUM_CH),
   parameter int CNT_WIDTH  = $clog2(BURST_LEN + 1)
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [NUM_CH-1:0]            ch_enable,
   input  logic [NUM_CH-1:0]            in_valid,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]            in_ready,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CH_WIDTH-1:0]          out_ch,
   input  logic                         out_ready,
   output logic                         busy,
   output logic [CH_WIDTH-1:0]          cur_ch
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t                             state;
   logic [CH_WIDTH-1:0]                grant;
   logic [CH_WIDTH-1:0]                last_grant;
   logic [CH_WIDTH-1:0]                next_grant;
   logic [CH_WIDTH-1:0]                scan_idx;
   logic [CNT_WIDTH-1:0]               beat_cnt;
   logic [NUM_CH-1:0][DATA_WIDTH-1:0]  ch_data;
   logic [NUM_CH-1:0]                  req;
   logic                               cken;
   logic                               xfer;
   logic                               last_beat;

   // Output register can take a new beat when empty or being drained.
   assign cken      = !out_valid || out_ready;
   assign req       = in_valid & ch_enable;
   assign xfer      = |(in_valid & in_ready);
   assign last_beat = (beat_cnt == CNT_WIDTH'(BURST_LEN - 1));
   assign busy      = (state == GRANT);
   assign cur_ch    = grant;

   // Per-channel unpack and ready. Dropping ch_enable kills ready in the
   // same cycle so no beat is taken from a channel being removed.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_data[i]  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      assign in_ready[i] = (state == GRANT) && (grant == CH_WIDTH'(i)) &&
                           ch_enable[i] && cken;
   end

   // Round-robin pick: scan last_grant+1, +2, ... wrapping. The loop runs
   // from the farthest offset down so the nearest requester wins. Offset
   // NUM_CH comes back to last_grant itself, so it is only chosen when no
   // other channel requests.
   always_comb begin
      next_grant = last_grant;
      scan_idx   = last_grant;
      for (int k = NUM_CH; k >= 1; k--) begin
         scan_idx = CH_WIDTH'((int'(last_grant) + k) % NUM_CH);
         if (req[scan_idx]) next_grant = scan_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= IDLE;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_ch     <= '0;
         beat_cnt   <= '0;
         grant      <= CH_WIDTH'(NUM_CH - 1);
         last_grant <= CH_WIDTH'(NUM_CH - 1);
      end else begin
         // Output stage loads every enabled cycle; out_valid marks whether a
         // real transfer happened. Everything holds while stalled.
         if (cken) begin
            out_valid <= xfer;
            out_data  <= ch_data[grant];
            out_ch    <= grant;
         end

         case (state)
            IDLE: begin
               if (|req) begin
                  grant    <= next_grant;
                  beat_cnt <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               // Release order: disabled, burst exhausted, source ran dry
               // (a ram_fifo read bubble also gives up the grant).
               if (!ch_enable[grant] || (xfer && last_beat) ||
                   (cken && !in_valid[grant])) begin
                  state      <= IDLE;
                  last_grant <= grant;
                  beat_cnt   <= '0;
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + CNT_WIDTH'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fifo_rr_scheduler
//   Bench for fifo_rr_scheduler. Main instance uses BURST_LEN=4; a second
//   instance with BURST_LEN=16 covers the single-channel latency case.
//   Sources are modelled as per-channel counters; every accepted input beat
//   is queued and must reappear at the output in order.
// -----------------------------------------------------------------------------
module tb_fifo_rr_scheduler;

   localparam int NCH = 4;
   localparam int DW  = 32;
   localparam int BL  = 4;
   localparam int BLB = 16;
   localparam int CHW = 2;

   logic                clk = 1'b0;
   logic                rstn;
   logic [NCH-1:0]      ch_enable;
   logic [NCH-1:0]      in_valid, in_ready, in_valid_b, in_ready_b;
   logic [NCH*DW-1:0]   in_data, in_data_b;
   logic                out_valid, out_ready, busy, out_valid_b, busy_b;
   logic [DW-1:0]       out_data, out_data_b;
   logic [CHW-1:0]      out_ch, cur_ch, out_ch_b, cur_ch_b;

   always #5 clk = ~clk;

   fifo_rr_scheduler #(.NUM_CH(NCH), .DATA_WIDTH(DW), .BURST_LEN(BL)) u_dut (
      .clk(clk), .rstn(rstn), .ch_enable(ch_enable), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
      .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready),
      .busy(busy), .cur_ch(cur_ch));

   fifo_rr_scheduler #(.NUM_CH(NCH), .DATA_WIDTH(DW), .BURST_LEN(BLB)) u_dut_b (
      .clk(clk), .rstn(rstn), .ch_enable(ch_enable), .in_valid(in_valid_b),
      .in_data(in_data_b), .in_ready(in_ready_b), .out_valid(out_valid_b),
      .out_data(out_data_b), .out_ch(out_ch_b), .out_ready(out_ready),
      .busy(busy_b), .cur_ch(cur_ch_b));

   typedef struct {
      logic [CHW-1:0] ch;
      logic [DW-1:0]  data;
   } beat_t;

   typedef struct {
      logic [NCH-1:0] en;
      logic [NCH-1:0] ir;
      logic           bsy;
      logic           ov;
      logic [CHW-1:0] och;
   } vec_t;

   beat_t          exp_q[$];
   int             n_cmp = 0;
   int             n_fail = 0;
   int             src_left[NCH];
   int             src_seq[NCH];
   bit             hold_pend;
   logic [DW-1:0]  hold_data;
   logic [CHW-1:0] hold_ch;
   int             burst;
   vec_t           tbl[36];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_src();
      for (int i = 0; i < NCH; i++) begin
         in_valid[i]          = (src_left[i] > 0);
         in_data[i*DW +: DW]  = {8'(i), 24'(src_seq[i])};
      end
   endtask

   // One clock: drive sources, check output side at negedge, record input
   // transfers, return just after the posedge.
   task automatic cycle();
      beat_t b;
      drive_src();
      @(negedge clk);
      if (hold_pend) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, hold_data);
         chk("hold_ch", out_ch, hold_ch);
      end
      hold_pend = rstn && out_valid && !out_ready;
      hold_data = out_data;
      hold_ch   = out_ch;
      if (rstn && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL sb_underflow: got ch %0d data %0h, expected no beat", out_ch, out_data);
         end else begin
            b = exp_q.pop_front();
            chk("sb_ch", out_ch, b.ch);
            chk("sb_data", out_data, b.data);
         end
      end
      if (!busy) burst = 0;
      for (int i = 0; i < NCH; i++) begin
         if (in_valid[i] && in_ready[i]) begin
            b.ch   = CHW'(i);
            b.data = in_data[i*DW +: DW];
            exp_q.push_back(b);
            src_seq[i]++;
            src_left[i]--;
            burst++;
            chk("burst_le_max", burst <= BL, 1);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      for (int i = 0; i < NCH; i++) src_left[i] = 0;
      cycle();
      cycle();
      exp_q.delete();
      hold_pend = 0;
      burst     = 0;
      rstn      = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < NCH; i++) src_left[i] = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 50 && (exp_q.size() != 0 || out_valid); c++) cycle();
      chk({name, "_drain_q"}, exp_q.size(), 0);
      chk({name, "_drain_ov"}, out_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      int   k, first, last, nout;
      int   seen[$];
      int   e5[3];
      logic prev_busy;

      rstn       = 1'b0;
      ch_enable  = '1;
      out_ready  = 1'b1;
      in_valid_b = '0;
      in_data_b  = '0;
      burst      = 0;
      hold_pend  = 0;
      for (int i = 0; i < NCH; i++) begin
         src_left[i] = 0;
         src_seq[i]  = 0;
      end

      // Reset state
      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cur_ch", cur_ch, 3);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cur_ch_b", cur_ch_b, 3);

      // Test 1: BURST_LEN=16 instance, only ch0 with 5 beats
      k = 0; first = -1; last = -1; nout = 0;
      in_valid_b     = 4'b0001;
      in_data_b[31:0] = 32'hB000_0000;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (out_valid_b && out_ready) begin
            if (first < 0) first = c;
            last = c;
            chk("t1_ch", out_ch_b, 0);
            chk("t1_data", out_data_b, 32'hB000_0000 + 32'(nout));
            nout++;
         end
         if (in_valid_b[0] && in_ready_b[0]) k++;
         @(posedge clk);
         #1;
         in_valid_b[0]   = (k < 5);
         in_data_b[31:0] = 32'hB000_0000 + 32'(k);
      end
      chk("t1_first_latency", first, 2);
      chk("t1_last_cycle", last, 6);
      chk("t1_nbeats", nout, 5);
      chk("t1_busy_end", busy_b, 0);

      // Test 2 + 4a: all channels valid, bursts of 4 with one idle cycle,
      // then ch1 disabled and skipped.
      tbl[0]  = '{4'hF, 4'h1, 1'b1, 1'b0, 2'd0};
      tbl[1]  = '{4'hF, 4'h1, 1'b1, 1'b1, 2'd0};
      tbl[2]  = '{4'hF, 4'h1, 1'b1, 1'b1, 2'd0};
      tbl[3]  = '{4'hF, 4'h1, 1'b1, 1'b1, 2'd0};
      tbl[4]  = '{4'hF, 4'h0, 1'b0, 1'b1, 2'd0};
      tbl[5]  = '{4'hF, 4'h2, 1'b1, 1'b0, 2'd0};
      tbl[6]  = '{4'hF, 4'h2, 1'b1, 1'b1, 2'd1};
      tbl[7]  = '{4'hF, 4'h2, 1'b1, 1'b1, 2'd1};
      tbl[8]  = '{4'hF, 4'h2, 1'b1, 1'b1, 2'd1};
      tbl[9]  = '{4'hF, 4'h0, 1'b0, 1'b1, 2'd1};
      tbl[10] = '{4'hF, 4'h4, 1'b1, 1'b0, 2'd0};
      tbl[11] = '{4'hF, 4'h4, 1'b1, 1'b1, 2'd2};
      tbl[12] = '{4'hF, 4'h4, 1'b1, 1'b1, 2'd2};
      tbl[13] = '{4'hF, 4'h4, 1'b1, 1'b1, 2'd2};
      tbl[14] = '{4'hF, 4'h0, 1'b0, 1'b1, 2'd2};
      tbl[15] = '{4'hF, 4'h8, 1'b1, 1'b0, 2'd0};
      tbl[16] = '{4'hF, 4'h8, 1'b1, 1'b1, 2'd3};
      tbl[17] = '{4'hF, 4'h8, 1'b1, 1'b1, 2'd3};
      tbl[18] = '{4'hF, 4'h8, 1'b1, 1'b1, 2'd3};
      tbl[19] = '{4'hF, 4'h0, 1'b0, 1'b1, 2'd3};
      tbl[20] = '{4'hF, 4'h1, 1'b1, 1'b0, 2'd0};
      tbl[21] = '{4'hF, 4'h1, 1'b1, 1'b1, 2'd0};
      tbl[22] = '{4'hF, 4'h1, 1'b1, 1'b1, 2'd0};
      tbl[23] = '{4'hF, 4'h1, 1'b1, 1'b1, 2'd0};
      tbl[24] = '{4'hD, 4'h0, 1'b0, 1'b1, 2'd0};
      tbl[25] = '{4'hD, 4'h4, 1'b1, 1'b0, 2'd0};
      tbl[26] = '{4'hD, 4'h4, 1'b1, 1'b1, 2'd2};
      tbl[27] = '{4'hD, 4'h4, 1'b1, 1'b1, 2'd2};
      tbl[28] = '{4'hD, 4'h4, 1'b1, 1'b1, 2'd2};
      tbl[29] = '{4'hD, 4'h0, 1'b0, 1'b1, 2'd2};
      tbl[30] = '{4'hD, 4'h8, 1'b1, 1'b0, 2'd0};
      tbl[31] = '{4'hD, 4'h8, 1'b1, 1'b1, 2'd3};
      tbl[32] = '{4'hD, 4'h8, 1'b1, 1'b1, 2'd3};
      tbl[33] = '{4'hD, 4'h8, 1'b1, 1'b1, 2'd3};
      tbl[34] = '{4'hD, 4'h0, 1'b0, 1'b1, 2'd3};
      tbl[35] = '{4'hD, 4'h1, 1'b1, 1'b0, 2'd0};
      for (int i = 0; i < NCH; i++) src_left[i] = 1000;
      out_ready = 1'b1;
      for (int v = 0; v < 36; v++) begin
         ch_enable = tbl[v].en;
         cycle();
         chk($sformatf("t2_v%0d_in_ready", v), in_ready, tbl[v].ir);
         chk($sformatf("t2_v%0d_busy", v), busy, tbl[v].bsy);
         chk($sformatf("t2_v%0d_out_valid", v), out_valid, tbl[v].ov);
         if (tbl[v].ov) chk($sformatf("t2_v%0d_out_ch", v), out_ch, tbl[v].och);
      end
      drain("t2");

      // Test 4b: drop ch_enable[2] mid-burst
      ch_enable = 4'hF;
      do_reset();
      src_left[2] = 1000;
      src_left[3] = 1000;
      cycle();
      chk("t4_grant_ch2", cur_ch, 2);
      chk("t4_ready_ch2", in_ready, 4'b0100);
      cycle();
      ch_enable = 4'b1011;
      #1;
      chk("t4_drop_ready", in_ready, 4'b0000);
      cycle();
      chk("t4_release_busy", busy, 0);
      cycle();
      chk("t4_next_ch3", cur_ch, 3);
      chk("t4_ready_ch3", in_ready, 4'b1000);
      drain("t4");

      // Test 5: ch0 drains after 3 beats, refilled ch0 waits its turn
      ch_enable = 4'hF;
      do_reset();
      src_left[0] = 3;
      for (int i = 1; i < NCH; i++) src_left[i] = 1000;
      for (int c = 0; c < 4; c++) cycle();
      chk("t5_busy_c4", busy, 1);
      cycle();
      chk("t5_release", busy, 0);
      chk("t5_last_ch0", cur_ch, 0);
      src_left[0] = 5;
      cycle();
      chk("t5_next_ch1", cur_ch, 1);
      chk("t5_next_busy", busy, 1);
      e5 = '{2, 3, 0};
      prev_busy = busy;
      for (int c = 0; c < 60 && seen.size() < 3; c++) begin
         cycle();
         if (busy && !prev_busy) seen.push_back(int'(cur_ch));
         prev_busy = busy;
      end
      chk("t5_ngrants", seen.size(), 3);
      for (int j = 0; j < seen.size(); j++) chk($sformatf("t5_grant%0d", j), seen[j], e5[j]);
      drain("t5");

      // Test 3: all channels valid, random backpressure
      do_reset();
      for (int i = 0; i < NCH; i++) src_left[i] = 1000;
      for (int c = 0; c < 400; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         cycle();
      end
      drain("t3");

      // Test 6: reset mid-burst with a stalled output beat
      do_reset();
      for (int i = 0; i < NCH; i++) src_left[i] = 1000;
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) cycle();
      chk("t6_busy", busy, 1);
      chk("t6_out_valid", out_valid, 1);
      out_ready = 1'b0;
      cycle();
      chk("t6_stall_valid", out_valid, 1);
      rstn = 1'b0;
      cycle();
      chk("t6_rst_out_valid", out_valid, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_out_data", out_data, 0);
      exp_q.delete();
      hold_pend = 0;
      burst     = 0;
      rstn      = 1'b1;
      out_ready = 1'b1;
      cycle();
      chk("t6_first_grant", cur_ch, 0);
      chk("t6_first_ready", in_ready, 4'b0001);
      drain("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
